// File: rtl/genomics_pipe_kernel_pkg.sv
// Shared op encoding and lane-count helper for the streaming lane kernel.
package genomics_pkg;

    typedef enum logic [1:0] {
        OP_PASS     = 2'd0,
        OP_ADD_WRAP = 2'd1,
        OP_ADD_SAT  = 2'd2,
        OP_SUB_SAT  = 2'd3
    } genomics_op_e;

    localparam int DEF_DATA_W = 512;
    localparam int DEF_LANE_W = 32;
    localparam int DEF_STAGES = 2;

    function automatic int lane_count(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

// File: rtl/genomics_pipe_kernel_if.sv
// Stream-in / stream-out / config / stats bundle; the kernel takes the slave side, the shell the master side.
// Widths must match the parameters of the kernel instance that receives the slave modport.
interface genomics_pipe_kernel_if #(
    parameter int C_DATA_WIDTH = 512,
    parameter int LANE_W       = 32
);
    logic                    in_ready;
    logic                    in_avail;
    logic [C_DATA_WIDTH-1:0] in_data;
    logic                    out_ready;
    logic                    out_avail;
    logic [C_DATA_WIDTH-1:0] out_data;
    logic [1:0]              cfg_op;
    logic [LANE_W-1:0]       cfg_k;
    logic [31:0]             stat_in_beats;
    logic [31:0]             stat_out_beats;
    logic [31:0]             stat_sat_lanes;

    modport master (
        output in_avail, in_data, out_ready, cfg_op, cfg_k,
        input  in_ready, out_avail, out_data, stat_in_beats, stat_out_beats, stat_sat_lanes
    );

    modport slave (
        input  in_avail, in_data, out_ready, cfg_op, cfg_k,
        output in_ready, out_avail, out_data, stat_in_beats, stat_out_beats, stat_sat_lanes
    );
endinterface

// File: rtl/genomics_pipe_kernel_lane_alu.sv
// One unsigned lane: pass / wrapping add / saturating add / saturating subtract with a clamp flag.
// Purely combinational; no backpressure of its own.
module genomics_lane_alu
    import genomics_pkg::*;
#(
    parameter int LANE_W = 32
) (
    input  logic [LANE_W-1:0] i_x,
    input  logic [LANE_W-1:0] i_k,
    input  genomics_op_e      i_op,
    output logic [LANE_W-1:0] o_y,
    output logic              o_sat
);
    logic [LANE_W:0] w_sum;
    logic [LANE_W:0] w_diff;

    // The extra top bit is carry-out for the sum and borrow for the difference.
    assign w_sum  = {1'b0, i_x} + {1'b0, i_k};
    assign w_diff = {1'b0, i_x} - {1'b0, i_k};

    always_comb begin
        o_y   = i_x;
        o_sat = 1'b0;
        case (i_op)
            OP_PASS: o_y = i_x;
            OP_ADD_WRAP: o_y = w_sum[LANE_W-1:0];
            OP_ADD_SAT: begin
                if (w_sum[LANE_W]) begin
                    o_y   = '1;
                    o_sat = 1'b1;
                end else begin
                    o_y = w_sum[LANE_W-1:0];
                end
            end
            OP_SUB_SAT: begin
                if (w_diff[LANE_W]) begin
                    o_y   = '0;
                    o_sat = 1'b1;
                end else begin
                    o_y = w_diff[LANE_W-1:0];
                end
            end
        endcase
    end
endmodule

// File: rtl/genomics_pipe_kernel.sv
// Lane kernel: op applied at stage-0 load, then a STAGES-deep elastic pipe; STAGES cycles latency, 1 beat/cycle.
// in_ready drops only when every stage is full and out_ready is low; GENOMICS_KERNEL_STATS_EN builds the stat counters.
module genomics_pipe_kernel
    import genomics_pkg::*;
#(
    parameter int C_DATA_WIDTH = DEF_DATA_W,
    parameter int LANE_W       = DEF_LANE_W,
    parameter int STAGES       = DEF_STAGES
) (
    input  logic               clk,
    input  logic               reset,
    genomics_pipe_kernel_if.slave bus
);
    localparam int LANES = lane_count(C_DATA_WIDTH, LANE_W);

    if ((C_DATA_WIDTH % LANE_W) != 0 || STAGES < 1) begin : g_bad_param
        $error("genomics_pipe_kernel: C_DATA_WIDTH must be a multiple of LANE_W and STAGES must be >= 1");
    end

    genomics_op_e            w_op;
    logic [C_DATA_WIDTH-1:0] w_alu_dat;
    logic [LANES-1:0]        w_sat;
    logic [STAGES-1:0]       w_load;
    logic                    w_in_xfer;
    logic                    w_out_xfer;

    logic [STAGES-1:0]       r_vld;
    logic [C_DATA_WIDTH-1:0] r_dat [STAGES];

    assign w_op = genomics_op_e'(bus.cfg_op);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        genomics_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .i_x  (bus.in_data[i*LANE_W +: LANE_W]),
            .i_k  (bus.cfg_k),
            .i_op (w_op),
            .o_y  (w_alu_dat[i*LANE_W +: LANE_W]),
            .o_sat(w_sat[i])
        );
    end

    // Walk from the output back: a stage can load if it is empty or its successor can load.
    always_comb begin
        logic g_room;
        g_room = bus.out_ready;
        w_load = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            w_load[s] = !r_vld[s] | g_room;
            g_room    = w_load[s];
        end
    end

    assign bus.in_ready  = reset & w_load[0];
    assign bus.out_avail = reset & r_vld[STAGES-1];
    assign bus.out_data  = reset ? r_dat[STAGES-1] : '0;
    assign w_in_xfer     = bus.in_avail & bus.in_ready;
    assign w_out_xfer    = bus.out_avail & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld <= '0;
            for (int s = 0; s < STAGES; s++) r_dat[s] <= '0;
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= bus.in_avail;
                if (bus.in_avail) r_dat[0] <= w_alu_dat;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (w_load[s]) begin
                    r_vld[s] <= r_vld[s-1];
                    if (r_vld[s-1]) r_dat[s] <= r_dat[s-1];
                end
            end
        end
    end

`ifdef GENOMICS_KERNEL_STATS_EN
    logic [31:0] w_sat_pop;
    logic [31:0] r_in_cnt;
    logic [31:0] r_out_cnt;
    logic [31:0] r_sat_cnt;

    always_comb begin
        w_sat_pop = '0;
        for (int i = 0; i < LANES; i++) w_sat_pop = w_sat_pop + 32'(w_sat[i]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_sat_cnt <= '0;
        end else begin
            if (w_in_xfer) begin
                r_in_cnt  <= r_in_cnt + 32'd1;
                r_sat_cnt <= r_sat_cnt + w_sat_pop;
            end
            if (w_out_xfer) r_out_cnt <= r_out_cnt + 32'd1;
        end
    end

    assign bus.stat_in_beats  = r_in_cnt;
    assign bus.stat_out_beats = r_out_cnt;
    assign bus.stat_sat_lanes = r_sat_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats     = ^{w_sat, w_in_xfer, w_out_xfer};
    assign bus.stat_in_beats  = '0;
    assign bus.stat_out_beats = '0;
    assign bus.stat_sat_lanes = '0;
`endif
endmodule

// File: tb/tb_genomics_pipe_kernel.sv
// Directed bench for genomics_pipe_kernel: vector table, streaming, random backpressure, cfg switch, mid-stream reset.
module tb_genomics_pipe_kernel;
    import genomics_pkg::*;

    localparam int DW = 512;
    localparam int LW = 32;
    localparam int ST = 2;
    localparam int NL = DW / LW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    genomics_pipe_kernel_if #(.C_DATA_WIDTH(DW), .LANE_W(LW)) bus();
    genomics_pipe_kernel #(.C_DATA_WIDTH(DW), .LANE_W(LW), .STAGES(ST)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            acc;
    } exp_t;

    typedef struct {
        logic [1:0]    op;
        logic [LW-1:0] k;
        logic [LW-1:0] x0;
        logic [LW-1:0] x1;
        logic [LW-1:0] y0;
        logic [LW-1:0] y1;
        int            ns;
    } vec_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   in_cnt = 0, out_cnt = 0, sat_cnt = 0, occ = 0;
    bit   mon_en = 1'b0;
    bit   chk_lat = 1'b0;
    int   or_mode = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rep(input logic [LW-1:0] x0, input logic [LW-1:0] x1);
        logic [DW-1:0] b;
        for (int i = 0; i < NL; i++) b[i*LW +: LW] = (i == 0) ? x0 : x1;
        return b;
    endfunction

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] b;
        for (int i = 0; i < NL; i++) b[i*LW +: LW] = LW'($urandom);
        return b;
    endfunction

    // Reference op on 64-bit unsigned integers, lane by lane.
    function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [LW-1:0] k,
                                            input logic [DW-1:0] d, output int ns);
        logic [DW-1:0]   r;
        longint unsigned x, kk, mx;
        mx = (64'd1 << LW) - 64'd1;
        kk = 64'(k);
        ns = 0;
        for (int i = 0; i < NL; i++) begin
            x = 64'(d[i*LW +: LW]);
            case (op)
                2'd1: r[i*LW +: LW] = LW'((x + kk) % (mx + 64'd1));
                2'd2: begin
                    if (x + kk > mx) begin r[i*LW +: LW] = LW'(mx); ns++; end
                    else r[i*LW +: LW] = LW'(x + kk);
                end
                2'd3: begin
                    if (kk > x) begin r[i*LW +: LW] = '0; ns++; end
                    else r[i*LW +: LW] = LW'(x - kk);
                end
                default: r[i*LW +: LW] = LW'(x);
            endcase
        end
        return r;
    endfunction

    task automatic send(input logic [1:0] op, input logic [LW-1:0] k, input logic [DW-1:0] d,
                        input logic [DW-1:0] e, input int ns, output int waited);
        int n = 0;
        bus.in_avail = 1'b1;
        bus.cfg_op   = op;
        bus.cfg_k    = k;
        bus.in_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        chk1("accept", bus.in_ready, 1'b1);
        if (bus.in_ready) begin
            exp_q.push_back('{e, cyc});
            sat_cnt += ns;
        end
        waited = n;
        @(posedge clk);
        #1;
        bus.in_avail = 1'b0;
        bus.in_data  = '1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk32("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic stats_chk(input string tag);
`ifdef GENOMICS_KERNEL_STATS_EN
        chk32({tag, "_stat_in"}, bus.stat_in_beats, 32'(in_cnt));
        chk32({tag, "_stat_out"}, bus.stat_out_beats, 32'(out_cnt));
        chk32({tag, "_stat_sat"}, bus.stat_sat_lanes, 32'(sat_cnt));
`else
        chk32({tag, "_stat_in"}, bus.stat_in_beats, 32'd0);
        chk32({tag, "_stat_out"}, bus.stat_out_beats, 32'd0);
        chk32({tag, "_stat_sat"}, bus.stat_sat_lanes, 32'd0);
`endif
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: ordering, stall stability, in_ready vs. occupancy, latency.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_dat;
        exp_t          e;
        prev_stall = 1'b0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                exp_q.delete();
                occ = 0; in_cnt = 0; out_cnt = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk1("stall_avail", bus.out_avail, 1'b1);
                    chk("stall_data", bus.out_data, prev_dat);
                end
                chk1("in_ready", bus.in_ready, !(occ == ST && !bus.out_ready));
                if (bus.out_avail && bus.out_ready) begin
                    chk1("beat_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e.d);
                        if (chk_lat) chk32("latency", 32'(cyc - e.acc), 32'(ST));
                    end
                    out_cnt++;
                end
                if (bus.in_avail && bus.in_ready) in_cnt++;
                occ += int'(bus.in_avail && bus.in_ready) - int'(bus.out_avail && bus.out_ready);
                prev_stall = bus.out_avail && !bus.out_ready;
                prev_dat   = bus.out_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt[9];
        int            w, ns;
        logic [DW-1:0] d, e;

        vt[0] = '{2'd0, 32'd5,        32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 0};
        vt[1] = '{2'd1, 32'd1,        32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0};
        vt[2] = '{2'd2, 32'h20,       32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16};
        vt[3] = '{2'd1, 32'h20,       32'hFFFFFFF0, 32'hFFFFFFF0, 32'h00000010, 32'h00000010, 0};
        vt[4] = '{2'd3, 32'd9,        32'd5,        32'd5,        32'd0,        32'd0,        16};
        vt[5] = '{2'd3, 32'd9,        32'd9,        32'd10,       32'd0,        32'd1,        0};
        vt[6] = '{2'd2, 32'd1,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 15};
        vt[7] = '{2'd3, 32'd0,        32'd0,        32'd7,        32'd0,        32'd7,        0};
        vt[8] = '{2'd2, 32'h10,       32'h7,        32'h80000000, 32'h17,       32'h80000010, 0};

        reset = 1'b0;
        bus.in_avail = 1'b0;
        bus.in_data  = '0;
        bus.cfg_op   = OP_PASS;
        bus.cfg_k    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_out_avail", bus.out_avail, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        #1;
        stats_chk("post_reset");

        for (int i = 0; i < 9; i++) begin
            send(vt[i].op, vt[i].k, rep(vt[i].x0, vt[i].x1), rep(vt[i].y0, vt[i].y1), vt[i].ns, w);
            wait_drain();
            stats_chk("vec");
        end

        // Back-to-back ADD_WRAP k=1 with out_ready held high.
        chk_lat = 1'b1;
        for (int b = 0; b < 100; b++) begin
            d = rnd_beat();
            e = model(OP_ADD_WRAP, 32'd1, d, ns);
            send(OP_ADD_WRAP, 32'd1, d, e, ns, w);
            chk32("stream_no_wait", 32'(w), 32'd1);
        end
        wait_drain();
        chk_lat = 1'b0;
        stats_chk("stream");

        or_mode = 1;
        for (int b = 0; b < 1000; b++) begin
            logic [1:0]    op;
            logic [LW-1:0] k;
            op = 2'($urandom_range(0, 3));
            k  = (b % 3 == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom);
            d  = rnd_beat();
            e  = model(op, k, d, ns);
            send(op, k, d, e, ns, w);
        end
        wait_drain();
        or_mode = 0;
        stats_chk("backpressure");

        // Lane value b+1: PASS for beats 0-9, SUB_SAT k=1 from beat 10.
        for (int b = 0; b < 20; b++) begin
            d = rep(LW'(b + 1), LW'(b + 1));
            if (b < 10) send(OP_PASS, 32'd1, d, d, 0, w);
            else        send(OP_SUB_SAT, 32'd1, d, rep(LW'(b), LW'(b)), 0, w);
        end
        wait_drain();
        stats_chk("cfg_switch");

        or_mode = 2;
        @(posedge clk);
        #2;
        for (int b = 0; b < ST; b++) begin
            d = rep(LW'(32'hDEAD0000 + b), LW'(32'hBEEF0000 + b));
            send(OP_PASS, 32'd0, d, d, 0, w);
        end
        #1;
        chk1("full_in_ready", bus.in_ready, 1'b0);
        chk1("full_out_avail", bus.out_avail, 1'b1);
        mon_en = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        or_mode = 0;
        chk1("midrst_in_ready", bus.in_ready, 1'b0);
        chk1("midrst_out_avail", bus.out_avail, 1'b0);
        chk("midrst_out_data", bus.out_data, '0);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        sat_cnt = 0;
        mon_en  = 1'b1;
        #1;
        chk1("release_out_avail", bus.out_avail, 1'b0);
        stats_chk("release");
        d = rep(32'hA5A5A5A5, 32'h5A5A5A5A);
        send(OP_PASS, 32'd0, d, d, 0, w);
        chk32("accept_after_reset", 32'(w), 32'd1);
        wait_drain();
        stats_chk("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
